// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: classifies each instruction, forms the sign-extended
// immediate, and carries the PC. It uses a two-entry output/skid buffer so in_ready comes from a flop.
module imm_decode_stage #(
    parameter int XLEN         = 32,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] TYPE_R   = 3'd0;
    localparam logic [2:0] TYPE_I   = 3'd1;
    localparam logic [2:0] TYPE_S   = 3'd2;
    localparam logic [2:0] TYPE_B   = 3'd3;
    localparam logic [2:0] TYPE_U   = 3'd4;
    localparam logic [2:0] TYPE_J   = 3'd5;
    localparam logic [2:0] TYPE_Z   = 3'd6;
    localparam logic [2:0] TYPE_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    // Signed size casts perform the sign extension from instr[31] up to XLEN.
    function automatic entry_t decode_entry(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        entry_t e;
        e.imm     = '0;
        e.fmt     = TYPE_R;
        e.illegal = 1'b0;
        e.pc      = pc;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.imm = XLEN'($signed(instr[31:20]));
                e.fmt = TYPE_I;
            end
            7'b0100011: begin
                e.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                e.fmt = TYPE_S;
            end
            7'b1100011: begin
                e.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                e.fmt = TYPE_B;
            end
            7'b1101111: begin
                e.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                e.fmt = TYPE_J;
            end
            7'b0110111, 7'b0010111: begin
                e.imm = XLEN'($signed({instr[31:12], 12'b0}));
                e.fmt = TYPE_U;
            end
            7'b1110011: begin
                if (ENABLE_ZICSR && instr[14]) begin
                    e.imm = XLEN'(instr[19:15]);
                    e.fmt = TYPE_Z;
                end else begin
                    e.imm = XLEN'($signed(instr[31:20]));
                    e.fmt = TYPE_I;
                end
            end
            7'b0110011, 7'b0001111: begin
                e.fmt = TYPE_R;
            end
            default: begin
                e.fmt     = TYPE_ILL;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    entry_t out_r, skid_r, dec_s, out_nxt_s, skid_nxt_s;
    logic   out_valid_r, skid_valid_r, out_valid_nxt_s, skid_valid_nxt_s;
    logic   accept_s, drain_s;
    logic   unused_funct3_s;

    assign unused_funct3_s = ^in_instr[13:12];

    // Next-state of the output and skid registers from the handshake and flush.
    always_comb begin
        dec_s            = decode_entry(in_instr, in_pc);
        accept_s         = in_valid & ~skid_valid_r;
        drain_s          = out_valid_r & out_ready;
        out_nxt_s        = out_r;
        skid_nxt_s       = skid_r;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            out_valid_nxt_s  = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (skid_valid_r) begin
            // in_ready is low here, so only the skid-to-output move can happen.
            if (drain_s) begin
                out_nxt_s        = skid_r;
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else begin
                out_valid_nxt_s  = out_valid_r;
            end
        end else if (accept_s) begin
            if (!out_valid_r || out_ready) begin
                out_nxt_s       = dec_s;
                out_valid_nxt_s = 1'b1;
            end else begin
                skid_nxt_s       = dec_s;
                skid_valid_nxt_s = 1'b1;
            end
        end else if (drain_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Pipeline state registers; reset overrides flush and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r        <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            out_r        <= out_nxt_s;
            skid_r       <= skid_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
        end
    end

    assign in_ready    = ~skid_valid_r;
    assign out_valid   = out_valid_r;
    assign out_imm     = out_r.imm;
    assign out_type    = out_r.fmt;
    assign out_illegal = out_r.illegal;
    assign out_pc      = out_r.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed test-plan steps followed by random traffic.
// Two instances are checked: XLEN=32 with Zicsr enabled, and XLEN=64 with Zicsr disabled.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_pc;
    logic [2:0]  a_out_type;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_pc;
    logic [2:0]  b_out_type;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .ENABLE_ZICSR(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_type(a_out_type), .out_illegal(a_out_illegal), .out_pc(a_out_pc)
    );

    imm_decode_stage #(.XLEN(64), .ENABLE_ZICSR(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_type(b_out_type), .out_illegal(b_out_illegal), .out_pc(b_out_pc)
    );

    // Reference decode: immediates built as integer values, negated by subtracting 2^width.
    function automatic void ref_dec(input logic [31:0] ins, input bit x64, input bit zc,
                                    output logic [63:0] imm, output logic [2:0] ty, output logic ill);
        longint v = 0;
        int op = int'(ins[6:0]);
        ty = 3'd0;
        ill = 1'b0;
        case (op)
            'h13, 'h03, 'h67: begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; ty = 3'd1; end
            'h23: begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v -= 4096;
                ty = 3'd2;
            end
            'h63: begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
                ty = 3'd3;
            end
            'h6f: begin
                v = longint'(ins[31]) * (64'd1 << 20) + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= (64'sd1 <<< 20)) v -= (64'sd1 <<< 21);
                ty = 3'd5;
            end
            'h37, 'h17: begin
                v = longint'(ins[31:12]) * 4096;
                if (v >= (64'sd1 <<< 31)) v -= (64'sd1 <<< 32);
                ty = 3'd4;
            end
            'h73: begin
                if (zc && ins[14]) begin v = longint'(ins[19:15]); ty = 3'd6; end
                else begin v = longint'(ins[31:20]); if (v >= 2048) v -= 4096; ty = 3'd1; end
            end
            'h33, 'h0f: begin v = 0; ty = 3'd0; end
            default: begin v = 0; ty = 3'd7; ill = 1'b1; end
        endcase
        imm = 64'(v);
        if (!x64) imm = imm & 64'h0000_0000_FFFF_FFFF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare both instances with the scoreboard head and expected buffer occupancy.
    task automatic check_model();
        logic [63:0] imm;
        logic [2:0]  ty;
        logic        ill;
        bit          has = (q.size() > 0);
        chk("a_valid", 64'(a_out_valid), 64'(has));
        chk("b_valid", 64'(b_out_valid), 64'(has));
        chk("a_ready", 64'(a_in_ready), 64'(q.size() < 2));
        chk("b_ready", 64'(b_in_ready), 64'(q.size() < 2));
        if (has) begin
            ref_dec(q[0].ins, 1'b0, 1'b1, imm, ty, ill);
            chk("a_imm", 64'(a_out_imm), imm);
            chk("a_type", 64'(a_out_type), 64'(ty));
            chk("a_ill", 64'(a_out_illegal), 64'(ill));
            chk("a_pc", 64'(a_out_pc), {32'h0, q[0].pc[31:0]});
            ref_dec(q[0].ins, 1'b1, 1'b0, imm, ty, ill);
            chk("b_imm", b_out_imm, imm);
            chk("b_type", 64'(b_out_type), 64'(ty));
            chk("b_ill", 64'(b_out_illegal), 64'(ill));
            chk("b_pc", b_out_pc, q[0].pc);
        end
    endtask

    // One clock: drive inputs, advance the scoreboard at the edge, check #1 later.
    task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                        input bit ordy, input bit fl, input bit rs);
        bit acc, drn;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; rst = rs;
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{ins: ins, pc: pc});
        end
        #1;
        check_model();
        if (rs) begin
            chk("rst_a_imm", 64'(a_out_imm), 64'h0);
            chk("rst_a_type", 64'(a_out_type), 64'h0);
            chk("rst_a_ill", 64'(a_out_illegal), 64'h0);
            chk("rst_a_pc", 64'(a_out_pc), 64'h0);
            chk("rst_b_imm", b_out_imm, 64'h0);
            chk("rst_b_pc", b_out_pc, 64'h0);
        end
    endtask

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6f,
                             7'h37, 7'h17, 7'h73, 7'h33, 7'h0f, 7'h7f};

    initial begin
        logic [31:0] ri;
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Single beats with known immediates.
        step(1'b1, 32'hFFF00093, 64'h100, 1'b1, 1'b0, 1'b0);
        chk("addi_imm", 64'(a_out_imm), 64'hFFFF_FFFF);
        chk("addi_pc", 64'(a_out_pc), 64'h100);
        step(1'b1, 32'hFE112E23, 64'h104, 1'b1, 1'b0, 1'b0);
        chk("sw_imm", 64'(a_out_imm), 64'hFFFF_FFFC);

        // Back-to-back formats.
        step(1'b1, 32'hFE000CE3, 64'h108, 1'b1, 1'b0, 1'b0);
        chk("beq_imm", 64'(a_out_imm), 64'hFFFF_FFF8);
        step(1'b1, 32'h001000EF, 64'h10C, 1'b1, 1'b0, 1'b0);
        chk("jal_imm", 64'(a_out_imm), 64'h800);
        step(1'b1, 32'h3402D073, 64'h110, 1'b1, 1'b0, 1'b0);
        chk("csr_z_type", 64'(a_out_type), 64'd6);
        chk("csr_noz_imm", b_out_imm, 64'h340);
        chk("csr_noz_type", 64'(b_out_type), 64'd1);
        step(1'b1, 32'h00000033, 64'h114, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000007F, 64'h118, 1'b1, 1'b0, 1'b0);
        chk("ill_flag", 64'(a_out_illegal), 64'd1);
        step(1'b1, 32'h800002B7, 64'h11C, 1'b1, 1'b0, 1'b0);
        chk("lui32_imm", 64'(a_out_imm), 64'h8000_0000);
        chk("lui64_imm", b_out_imm, 64'hFFFF_FFFF_8000_0000);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A and B held, C waits upstream until in_ready returns.
        step(1'b1, 32'h00500113, 64'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00A12023, 64'h204, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, 64'h208, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, 64'h208, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, 64'h208, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, 64'h208, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Flush with two entries held and a same-cycle input.
        step(1'b1, 32'h00100093, 64'h300, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 64'h304, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00300093, 64'h308, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream.
        step(1'b1, 32'hFFF00093, 64'h400, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFE112E23, 64'h404, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFE000CE3, 64'h408, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ri = $urandom();
            if ($urandom_range(0, 7) != 0) ri[6:0] = ops[$urandom_range(0, 11)];
            step($urandom_range(0, 3) != 0, ri, {$urandom(), $urandom()},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered immediate-decode stage for the RV pipeline's decode path.
- Classifies each instruction by opcode and produces one selected, sign-extended immediate at XLEN width, with a format code and an illegal flag.
- Carries the PC alongside each instruction.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is purely registered.
- Supports flush on a branch mispredict or trap.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. Immediates and PC are XLEN bits.
- ENABLE_ZICSR, 1, when 1, SYSTEM instructions with funct3[2]=1 decode as a zimm (Z) immediate; when 0 they decode as I.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  drops all held entries and any same-cycle input.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered).
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  selected immediate.
- out_type  out  3  format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z, 7=illegal.
- out_illegal  out  1  opcode not recognised.
- out_pc  out  XLEN  PC of the output entry.

Behaviour:
- Reset is synchronous, sampled at the clock edge.
  - While rst is high, and after reset: out_valid=0, out_imm=0, out_type=0, out_illegal=0, out_pc=0, skid empty, in_ready=1.
  - rst has priority over flush and over all handshakes.
- Opcode decode (instr[6:0]):
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 1101111 -> J.
  - 0110111 LUI, 0010111 AUIPC -> U.
  - 1110011 SYSTEM -> Z if ENABLE_ZICSR and funct3[2]=1, else I.
  - 0110011 OP, 0001111 FENCE -> R, imm=0.
  - Anything else -> type 7, out_illegal=1, imm=0.
- Immediate formation:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U = sext({instr[31:12], 12'b0}); for XLEN=64, bit 31 is replicated into [63:32].
  - Z = zext(instr[19:15]).
  - All sign extension is from instr[31] to full XLEN.
- Latency:
  - One cycle from the accepting edge to out_valid.
  - Outputs come straight from registers; there is no combinational in->out path.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - out_* fields hold stable while out_valid && !out_ready.
- Buffering rules, evaluated at each edge:
  - Accept while the output register is empty or being drained: decoded data goes to the output register.
  - Accept while the output register is full and stalled: decoded data goes to the skid register, and in_ready drops next cycle.
  - Output drained with skid full: skid moves to the output register and in_ready rises next cycle. A same-cycle accept is impossible here because in_ready=0.
  - Program order is always preserved.
- Flush:
  - Clears out_valid and skid_valid at the edge.
  - Any input accepted in the flush cycle is discarded.
  - Data registers may retain stale values, but out_valid=0.
  - in_ready=1 in the cycle after flush.
- Simultaneous in and out transfer with skid empty: throughput is 1/cycle with no bubble.
- Bubble: no accept and output drained -> out_valid=0 next cycle.

Test Plan:
- Reset, then a single beat with out_ready=1:
  - 0xFFF00093 (addi x1,x0,-1), pc=0x100 -> next cycle out_imm=0xFFFFFFFF, type=1, out_pc=0x100.
  - 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, type=2.
- Formats, back-to-back with out_ready=1 and outputs arriving on consecutive cycles:
  - 0xFE000CE3 -> 0xFFFFFFF8, type 3.
  - 0x001000EF -> 0x00000800, type 5.
  - 0x3402D073 -> 0x00000005, type 6.
  - 0x00000033 -> 0, type 0.
  - 0x0000007F -> illegal=1, type 7.
- XLEN=64 with 0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000, type 4. Same instruction at XLEN=32 -> 0x80000000.
- ENABLE_ZICSR=0 with 0x3402D073 -> type 1, out_imm=0x00000340.
- Backpressure:
  - Hold out_ready=0, offer instructions A, B, C on consecutive cycles -> A and B accepted, in_ready=0 thereafter, C is held upstream.
  - Raise out_ready -> outputs A, B, C in order, no loss or duplication, out_* stable throughout the stall.
- Flush and reset:
  - With two entries held, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flush-cycle input never appears.
  - rst asserted mid-stream -> all outputs zero the next cycle.
